// File: rtl/exc_pkg.sv
// Shared types and encodings for the exception control stage.
package exc_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTake    = 3'd1,
    StHandler = 3'd2,
    StRet     = 3'd3,
    StFault   = 3'd4
  } exc_state_t;

  // Next-PC source codes.
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_VEC = 2'b01;
  localparam logic [1:0] PCSEL_ERR = 2'b10;

  // Cause codes produced by the decoder.
  localparam logic [3:0] ESTAT_IRQ   = 4'b0001;
  localparam logic [3:0] ESTAT_UNDEF = 4'b0010;

  // MRS source select codes.
  localparam logic [1:0] SYSSEL_ERR    = 2'b00;
  localparam logic [1:0] SYSSEL_ESR    = 2'b01;
  localparam logic [1:0] SYSSEL_STATUS = 2'b10;
  localparam logic [1:0] SYSSEL_RSVD   = 2'b11;

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder <-> exception control signal bundle.
interface exception_ctrl_if #(
  parameter int unsigned N = 64
);
  logic         Exc;
  logic [3:0]   EStatus;
  logic         ERet;
  logic [N-1:0] PC;
  logic [1:0]   SysRegSel;
  logic [N-1:0] SysRegOut;
  logic         ExcAck;
  logic [1:0]   PCSel;
  logic         Flush;
  logic         InHandler;
  logic         Halt;

  // Decoder / pipeline side.
  modport master (
    output Exc, EStatus, ERet, PC, SysRegSel,
    input  SysRegOut, ExcAck, PCSel, Flush, InHandler, Halt
  );

  // Exception control side.
  modport slave (
    input  Exc, EStatus, ERet, PC, SysRegSel,
    output SysRegOut, ExcAck, PCSel, Flush, InHandler, Halt
  );
endinterface

// File: rtl/exc_sysregs.sv
// ERR/ESR exception system registers and the MRS read mux.
module exc_sysregs
  import exc_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         err_we,
  input  logic [N-1:0] err_wdata,
  input  logic         esr_we,
  input  logic [3:0]   esr_wdata,
  input  logic [1:0]   sel,
  input  logic         halt,
  input  logic         in_handler,
  output logic [N-1:0] rdata
);

  logic [N-1:0] err_q;
  logic [3:0]   esr_q;

  // Register updates; each register has its own write enable.
  always_ff @(posedge clk) begin
    if (Reset) begin
      err_q <= '0;
      esr_q <= '0;
    end else begin
      if (err_we) err_q <= err_wdata;
      if (esr_we) esr_q <= esr_wdata;
    end
  end

  // Read mux; a read in the write cycle sees the old value.
  always_comb begin
    rdata = '0;
    unique case (sel)
      SYSSEL_ERR:    rdata = err_q;
      SYSSEL_ESR:    rdata = {{(N-4){1'b0}}, esr_q};
      SYSSEL_STATUS: rdata = {{(N-2){1'b0}}, halt, in_handler};
      SYSSEL_RSVD:   rdata = '0;
      default:       rdata = '0;
    endcase
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception control FSM: capture, vector redirect, return and double-fault halt.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned  N           = 64,
  parameter logic [N-1:0] VECTOR_ADDR = N'(64'hD8)
) (
  input logic            clk,
  input logic            Reset,
  exception_ctrl_if.slave bus
);

  exc_state_t state_q, state_d;
  logic       err_we;
  logic       esr_we;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state and capture enables; Exc outranks ERet.
  always_comb begin
    state_d = state_q;
    err_we  = 1'b0;
    esr_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.Exc) begin
          err_we  = 1'b1;
          esr_we  = 1'b1;
          state_d = StTake;
        end
      end
      StTake: state_d = StHandler;
      StHandler: begin
        if (bus.Exc) begin
          // IRQs are masked in the handler; anything else is a double fault.
          if (bus.EStatus != ESTAT_IRQ) begin
            esr_we  = 1'b1;
            state_d = StFault;
          end
        end else if (bus.ERet) begin
          state_d = StRet;
        end
      end
      StRet:   state_d = StIdle;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from state only.
  always_comb begin
    bus.ExcAck    = 1'b0;
    bus.PCSel     = PCSEL_SEQ;
    bus.Flush     = 1'b0;
    bus.InHandler = 1'b0;
    bus.Halt      = 1'b0;
    unique case (state_q)
      StIdle: ;
      StTake: begin
        bus.ExcAck = 1'b1;
        bus.PCSel  = PCSEL_VEC;
        bus.Flush  = 1'b1;
      end
      StHandler: bus.InHandler = 1'b1;
      StRet: begin
        bus.PCSel     = PCSEL_ERR;
        bus.Flush     = 1'b1;
        bus.InHandler = 1'b1;
      end
      StFault: begin
        bus.Halt  = 1'b1;
        bus.Flush = 1'b1;
      end
      default: ;
    endcase
  end

  // VECTOR_ADDR is consumed by the fetch stage through PCSel; kept here as the
  // single point of definition for the handler entry.
  logic [N-1:0] vector_addr;
  assign vector_addr = VECTOR_ADDR;
  logic unused_vector;
  assign unused_vector = ^vector_addr;

  exc_sysregs #(
    .N (N)
  ) u_sysregs (
    .clk        (clk),
    .Reset      (Reset),
    .err_we     (err_we),
    .err_wdata  (bus.PC),
    .esr_we     (esr_we),
    .esr_wdata  (bus.EStatus),
    .sel        (bus.SysRegSel),
    .halt       (bus.Halt),
    .in_handler (bus.InHandler),
    .rdata      (bus.SysRegOut)
  );

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception control stage downstream of the main decoder: consumes the decoder's `Exc`, `EStatus` and `ERet` and turns them into the processor's exception behaviour. On an exception it captures the return address and cause into system registers and redirects fetch to the exception vector. It returns the `ExcAck` acknowledge to the decoder, sequences `ERet` back to the saved address, and serves `ERR`/`ESR` to the `MRS` datapath read.

## Interface

Parameters:
- `N`, 64: datapath / PC width.
- `VECTOR_ADDR`, 64'hD8: exception handler entry address (N bits).

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `Reset`  in  1  reset, synchronous, active-high.
- `Exc`  in  1  exception request from decoder (undefined opcode or external IRQ).
- `EStatus`  in  4  cause code from decoder: 0001 IRQ, 0010 undefined instruction; others recorded as-is.
- `ERet`  in  1  exception-return request from decoder.
- `PC`  in  N  address of the instruction currently in decode (the one raising `Exc`).
- `SysRegSel`  in  2  `MRS` source: 00 ERR, 01 ESR, 10 status, 11 reserved.
- `SysRegOut`  out  N  selected system register, zero-extended.
- `ExcAck`  out  1  one-cycle acknowledge to decoder (feeds `ExtIAck = ExcAck & ExtIRQ`).
- `PCSel`  out  2  next-PC source: 00 sequential/branch, 01 `VECTOR_ADDR`, 10 ERR.
- `Flush`  out  1  squash the instruction in decode/fetch this cycle.
- `InHandler`  out  1  executing inside the handler (IRQs masked).
- `Halt`  out  1  double fault; core must stop fetching.

## Operation

States: IDLE, TAKE, HANDLER, RET, FAULT.
- IDLE: `Exc`=1 → ERR←PC, ESR←EStatus, next TAKE. Otherwise, including `ERet`=1 alone, stay IDLE (stray ERet ignored, PCSel 00).
- TAKE: ExcAck=1, PCSel=01, Flush=1; `Exc`/`ERet` ignored; next HANDLER.
- HANDLER: InHandler=1.
  - `Exc`=1 with EStatus=0001: masked, no capture, no ack, stay.
  - `Exc`=1 with any other EStatus: ESR←EStatus (ERR unchanged), next FAULT.
  - `ERet`=1 with `Exc`=0: next RET.
  - Otherwise stay.
- RET: PCSel=10, Flush=1, InHandler=1; next IDLE.
- FAULT: Halt=1, Flush=1, PCSel=00; remains until `Reset`.

Priority rules:
- `Exc` outranks `ERet` when both are high. The decoder's default case raises both for an undefined opcode.
- `Reset` outranks everything.

Outputs:
- ExcAck, PCSel, Flush, InHandler and Halt are decoded purely from state (Moore); no input-to-output combinational path.
- SysRegOut is combinational on SysRegSel and the registers:
  - 00 → ERR
  - 01 → {(N-4)'0, ESR}
  - 10 → {(N-2)'0, Halt, InHandler}
  - 11 → 0

## Timing

- Reset: on a rising edge with Reset=1 the next state is IDLE and ERR=0, ESR=0. All outputs are then 0, PCSel=00, SysRegOut=0 for sel 00/01/10. This also applies mid-TAKE, mid-RET or in FAULT; a pending ExcAck is dropped.
- Exception latency: Exc sampled at edge t → TAKE during cycle t+1 (ExcAck/Flush/PCSel=01 high exactly one cycle) → HANDLER from t+2. Fetch at VECTOR_ADDR in t+2.
- ERet latency: sampled at edge t in HANDLER → RET in t+1 → IDLE from t+2. Fetch at ERR in t+2.
- ExcAck is exactly one cycle per taken exception. The IRQ source must drop ExtIRQ by the end of HANDLER; a still-high ExtIRQ after RET is taken as a new exception.
- ERR/ESR are updated only on the capture edges listed above. They are stable for MRS reads throughout HANDLER. The MRS read in the cycle ERR is written returns the old value.
- Back-to-back: Exc high in the first IDLE cycle after RET is taken normally (no dead cycle).

## Structure

- Package `exc_pkg`:
  - state enum `exc_state_t`.
  - PCSel codes `PCSEL_SEQ`/`PCSEL_VEC`/`PCSEL_ERR`.
  - EStatus codes `ESTAT_IRQ`=4'b0001, `ESTAT_UNDEF`=4'b0010.
  - SysRegSel codes.
- One sub-module, `exc_sysregs`: ERR (N bits) and ESR (4 bits) with independent write enables, synchronous Reset, and the SysRegOut read mux. The FSM stays in `exception_ctrl`.

## Test plan

- Reset then idle, PC=0x40, no Exc → PCSel=00, ExcAck=0, SysRegOut(sel 00)=0, InHandler=0.
- Exc=1, EStatus=0010, ERet=1, PC=0x40 for one cycle → next cycle ExcAck=1, PCSel=01, Flush=1; then InHandler=1, ERR=0x40, ESR=0010.
- In HANDLER, Exc=1, EStatus=0001 → no ExcAck, ESR stays 0010. Then ERet=1 → one cycle PCSel=10, Flush=1, then IDLE with InHandler=0.
- In HANDLER, Exc=1, EStatus=0010 → FAULT: Halt=1 held 10 cycles, ESR=0010, ERR unchanged. Reset → all outputs 0.
- Reset asserted during TAKE → ExcAck low next cycle, state IDLE, ERR=0, ESR=0.
- ERet=1 with Exc=0 while IDLE → no state change, PCSel=00, Flush=0.
